// File: rtl/audio_stream_pkg.sv
// Shared definitions for the audio stream FIFO PIO: register map, STATUS/CONTROL bit
// positions and the level-width helper.
package audio_stream_pkg;

    localparam logic [1:0] ADDR_RX_DATA = 2'd0;
    localparam logic [1:0] ADDR_TX_DATA = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_CONTROL = 2'd3;

    localparam int unsigned STAT_RX_OVF   = 16;
    localparam int unsigned STAT_TX_UNF   = 17;
    localparam int unsigned STAT_TX_OVF   = 18;
    localparam int unsigned STAT_RX_EMPTY = 19;
    localparam int unsigned STAT_TX_FULL  = 20;

    localparam int unsigned CTRL_CLR_RX_OVF = 0;
    localparam int unsigned CTRL_CLR_TX_UNF = 1;
    localparam int unsigned CTRL_CLR_TX_OVF = 2;
    localparam int unsigned CTRL_FLUSH_RX   = 3;
    localparam int unsigned CTRL_FLUSH_TX   = 4;
    localparam int unsigned CTRL_IRQ_EN     = 5;
    localparam int unsigned CTRL_IRQ_TX_EN  = 6;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock FIFO with flush; flush overrides any same-cycle push or pop.
module audio_sync_fifo
    import audio_stream_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    localparam int LVL_W = clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [LVL_W-2:0]  wr_ptr;
    logic [LVL_W-2:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    // A full FIFO still accepts a push when a pop frees the head slot that same cycle.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/audio_stream_fifo_pio.sv
// Avalon-MM audio PIO with RX/TX sample FIFOs, fill levels and sticky error flags.
// Optional interrupt logic is built when AUDIO_STREAM_IRQ_EN is defined.
module audio_stream_fifo_pio
    import audio_stream_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int SIGN_EXT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_port,
    input  logic              out_ready,
    output logic              irq
);

    localparam int LVL_W = clog2(DEPTH) + 1;

    logic              rd, wr, ctrl_wr;
    logic              rx_rd, rx_flush, rx_take;
    logic              tx_wr, tx_flush, tx_take;
    logic [DATA_W-1:0] rx_head, tx_head;
    logic              rx_full, rx_empty, tx_full, tx_empty;
    logic [LVL_W-1:0]  rx_level, tx_level;
    logic              rx_ovf, tx_unf, tx_ovf;
    logic [7:0]        threshold;
    logic [31:0]       rx_ext, status, ctrl_rd, rd_mux;
    logic              unused_wd;

    assign rd       = chipselect & ~read_n;
    assign wr       = chipselect & ~write_n;
    assign ctrl_wr  = wr & (address == ADDR_CONTROL);
    assign rx_rd    = rd & (address == ADDR_RX_DATA);
    assign tx_wr    = wr & (address == ADDR_TX_DATA);
    assign rx_flush = ctrl_wr & writedata[CTRL_FLUSH_RX];
    assign tx_flush = ctrl_wr & writedata[CTRL_FLUSH_TX];
    assign rx_take  = rx_rd & ~rx_empty & ~rx_flush;
    assign tx_take  = out_ready & ~tx_empty & ~tx_flush;
    assign unused_wd = ^writedata;

    audio_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (rx_rd),
        .flush (rx_flush),
        .wdata (in_port),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    audio_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_wr),
        .pop   (out_ready),
        .flush (tx_flush),
        .wdata (writedata[DATA_W-1:0]),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    // Sticky flags: a same-cycle set overrides the W1C clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ovf <= 1'b0;
            tx_unf <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            rx_ovf <= (rx_ovf & ~(ctrl_wr & writedata[CTRL_CLR_RX_OVF]))
                    | (in_valid & rx_full & ~rx_take & ~rx_flush);
            tx_unf <= (tx_unf & ~(ctrl_wr & writedata[CTRL_CLR_TX_UNF]))
                    | (out_ready & tx_empty);
            tx_ovf <= (tx_ovf & ~(ctrl_wr & writedata[CTRL_CLR_TX_OVF]))
                    | (tx_wr & tx_full & ~tx_take & ~tx_flush);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port  <= '0;
            threshold <= '0;
        end else begin
            if (tx_take) out_port  <= tx_head;
            if (ctrl_wr) threshold <= writedata[15:8];
        end
    end

    always_comb begin
        rx_ext = (SIGN_EXT != 0 && rx_head[DATA_W-1]) ? '1 : '0;
        rx_ext[DATA_W-1:0] = rx_head;
    end

    always_comb begin
        status                = '0;
        status[7:0]           = 8'(rx_level);
        status[15:8]          = 8'(tx_level);
        status[STAT_RX_OVF]   = rx_ovf;
        status[STAT_TX_UNF]   = tx_unf;
        status[STAT_TX_OVF]   = tx_ovf;
        status[STAT_RX_EMPTY] = rx_empty;
        status[STAT_TX_FULL]  = tx_full;
    end

`ifdef AUDIO_STREAM_IRQ_EN
    logic irq_enable, irq_tx_enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_enable    <= 1'b0;
            irq_tx_enable <= 1'b0;
            irq           <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_enable    <= writedata[CTRL_IRQ_EN];
                irq_tx_enable <= writedata[CTRL_IRQ_TX_EN];
            end
            irq <= (irq_enable & (8'(rx_level) >= threshold) & (threshold != '0))
                 | (irq_tx_enable & (8'(tx_level) < threshold))
                 | (irq_enable & (rx_ovf | tx_unf | tx_ovf));
        end
    end

    always_comb begin
        ctrl_rd                 = '0;
        ctrl_rd[15:8]           = threshold;
        ctrl_rd[CTRL_IRQ_EN]    = irq_enable;
        ctrl_rd[CTRL_IRQ_TX_EN] = irq_tx_enable;
    end
`else
    assign irq = 1'b0;

    always_comb begin
        ctrl_rd       = '0;
        ctrl_rd[15:8] = threshold;
    end
`endif

    always_comb begin
        rd_mux = '0;
        if (rd) begin
            case (address)
                ADDR_RX_DATA: rd_mux = rx_empty ? '0 : rx_ext;
                ADDR_STATUS:  rd_mux = status;
                ADDR_CONTROL: rd_mux = ctrl_rd;
                default:      rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_mux;
    end

endmodule

// File: tb/tb_audio_stream_fifo_pio.sv
// Self-checking bench for audio_stream_fifo_pio against a queue-based reference model.
module tb_audio_stream_fifo_pio;

    localparam int DATA_W   = 16;
    localparam int DEPTH    = 16;
    localparam int SIGN_EXT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect, read_n, write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] in_port;
    logic        in_valid;
    logic [15:0] out_port;
    logic        out_ready;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [15:0] rx_q[$];
    logic [15:0] tx_q[$];
    bit          m_rovf, m_tunf, m_tovf, m_ien, m_iten;
    logic [7:0]  m_thr;
    logic [15:0] m_out;

    always #5 clk = ~clk;

    audio_stream_fifo_pio #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SIGN_EXT(SIGN_EXT)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .in_valid   (in_valid),
        .out_port   (out_port),
        .out_ready  (out_ready),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic [15:0] s);
        if (SIGN_EXT != 0) return {{16{s[15]}}, s};
        return {16'h0, s};
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[7:0]  = 8'(rx_q.size());
        s[15:8] = 8'(tx_q.size());
        s[16]   = m_rovf;
        s[17]   = m_tunf;
        s[18]   = m_tovf;
        s[19]   = (rx_q.size() == 0);
        s[20]   = (tx_q.size() == DEPTH);
        return s;
    endfunction

    function automatic logic m_irq();
`ifdef AUDIO_STREAM_IRQ_EN
        return (m_ien && rx_q.size() >= int'(m_thr) && m_thr != 0)
            || (m_iten && tx_q.size() < int'(m_thr))
            || (m_ien && (m_rovf || m_tunf || m_tovf));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_ctrl();
        logic [31:0] c;
        c = {16'h0, m_thr, 8'h0};
`ifdef AUDIO_STREAM_IRQ_EN
        c[5] = m_ien;
        c[6] = m_iten;
`endif
        return c;
    endfunction

    task automatic model_reset();
        rx_q.delete();
        tx_q.delete();
        {m_rovf, m_tunf, m_tovf, m_ien, m_iten} = '0;
        m_thr = '0;
        m_out = '0;
    endtask

    // One bus/stream cycle: model computes expected outputs, DUT is clocked, outputs compared.
    task automatic cycle(input bit cs, input bit rdn_act, input bit wrn_act, input logic [1:0] a,
                         input logic [31:0] wd, input bit iv, input logic [15:0] ip, input bit ordy);
        logic [31:0] exp_rd;
        logic        exp_irq;
        bit          c_wr, s_rovf, s_tunf, s_tovf;
        chipselect = cs; read_n = ~rdn_act; write_n = ~wrn_act; address = a;
        writedata = wd; in_valid = iv; in_port = ip; out_ready = ordy;

        exp_rd = '0;
        if (cs && rdn_act) begin
            case (a)
                2'd0: exp_rd = (rx_q.size() > 0) ? ext(rx_q[0]) : '0;
                2'd2: exp_rd = m_status();
                2'd3: exp_rd = m_ctrl();
                default: exp_rd = '0;
            endcase
        end
        exp_irq = m_irq();

        c_wr = cs && wrn_act && a == 2'd3;
        {s_rovf, s_tunf, s_tovf} = '0;
        if (c_wr && wd[3]) rx_q.delete();
        else begin
            if (cs && rdn_act && a == 2'd0 && rx_q.size() > 0) void'(rx_q.pop_front());
            if (iv) begin
                if (rx_q.size() < DEPTH) rx_q.push_back(ip);
                else s_rovf = 1;
            end
        end
        if (ordy && tx_q.size() == 0) s_tunf = 1;
        if (c_wr && wd[4]) tx_q.delete();
        else begin
            if (ordy && tx_q.size() > 0) m_out = tx_q.pop_front();
            if (cs && wrn_act && a == 2'd1) begin
                if (tx_q.size() < DEPTH) tx_q.push_back(wd[15:0]);
                else s_tovf = 1;
            end
        end
        m_rovf = (m_rovf && !(c_wr && wd[0])) || s_rovf;
        m_tunf = (m_tunf && !(c_wr && wd[1])) || s_tunf;
        m_tovf = (m_tovf && !(c_wr && wd[2])) || s_tovf;
        if (c_wr) begin
            m_thr  = wd[15:8];
            m_ien  = wd[5];
            m_iten = wd[6];
        end

        @(posedge clk);
        #1;
        check("readdata", readdata, exp_rd);
        check("out_port", {16'h0, out_port}, {16'h0, m_out});
        check("irq", {31'h0, irq}, {31'h0, exp_irq});
    endtask

    task automatic idle();
        cycle(0, 0, 0, 2'd0, '0, 0, '0, 0);
    endtask
    task automatic push(input logic [15:0] s);
        cycle(0, 0, 0, 2'd0, '0, 1, s, 0);
    endtask
    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        cycle(1, 1, 0, a, '0, 0, '0, 0);
        d = readdata;
    endtask
    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        cycle(1, 0, 1, a, d, 0, '0, 0);
    endtask
    task automatic strobe_out();
        cycle(0, 0, 0, 2'd0, '0, 0, '0, 1);
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b1;
        {chipselect, in_valid, out_ready} = '0;
        read_n = 1'b1; write_n = 1'b1; address = '0; writedata = '0; in_port = '0;
        model_reset();
        #12;
        check("reset_readdata", readdata, 32'h0);
        check("reset_out_port", {16'h0, out_port}, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;

        reg_read(2'd2, d);
        check("reset_status", d, 32'h0008_0000);

        for (int i = 1; i <= 16; i++) push(16'(i));
        for (int i = 1; i <= 16; i++) begin
            reg_read(2'd0, d);
            check("rx_fill_data", d, 32'(i));
        end
        reg_read(2'd2, d);
        check("rx_empty_after_drain", {31'h0, d[19]}, 32'h1);
        reg_read(2'd0, d);
        check("rx_read_empty", d, 32'h0);

        push(16'h8000);
        reg_read(2'd0, d);
        check("sign_ext", d, (SIGN_EXT != 0) ? 32'hFFFF_8000 : 32'h0000_8000);

        for (int i = 0; i < 17; i++) push(16'(16'h100 + i));
        reg_read(2'd2, d);
        check("rx_ovf_flag", {31'h0, d[16]}, 32'h1);
        check("rx_ovf_level", {24'h0, d[7:0]}, 32'd16);
        reg_write(2'd3, 32'h1);
        reg_read(2'd2, d);
        check("rx_ovf_cleared", {31'h0, d[16]}, 32'h0);

        cycle(1, 1, 0, 2'd0, '0, 1, 16'hAAAA, 0);
        reg_read(2'd2, d);
        check("full_push_pop_level", {24'h0, d[7:0]}, 32'd16);
        check("full_push_pop_noovf", {31'h0, d[16]}, 32'h0);
        cycle(1, 0, 1, 2'd3, 32'h8, 1, 16'h5555, 0);
        reg_read(2'd2, d);
        check("rx_flush_level", {24'h0, d[7:0]}, 32'd0);
        check("rx_flush_noovf", {31'h0, d[16]}, 32'h0);

        reg_write(2'd1, 32'h1234);
        strobe_out();
        check("tx_first_pop", {16'h0, out_port}, 32'h1234);
        strobe_out();
        check("tx_underflow_hold", {16'h0, out_port}, 32'h1234);
        reg_read(2'd2, d);
        check("tx_underflow_flag", {31'h0, d[17]}, 32'h1);
        reg_write(2'd3, 32'h2);

        for (int i = 0; i < 17; i++) reg_write(2'd1, 32'(16'h200 + i));
        reg_read(2'd2, d);
        check("tx_ovf_flag", {31'h0, d[18]}, 32'h1);
        check("tx_full_level", {24'h0, d[15:8]}, 32'd16);
        check("tx_full_flag", {31'h0, d[20]}, 32'h1);
        cycle(1, 0, 1, 2'd1, 32'h0BAD, 0, '0, 1);
        reg_read(2'd2, d);
        check("tx_full_wr_pop_level", {24'h0, d[15:8]}, 32'd16);
        reg_write(2'd3, 32'h14);
        reg_read(2'd2, d);
        check("tx_flush_clear", d, 32'h0008_0000);

`ifdef AUDIO_STREAM_IRQ_EN
        reg_write(2'd3, 32'h0420);
        for (int i = 0; i < 4; i++) push(16'(16'h40 + i));
        idle();
        check("irq_at_threshold", {31'h0, irq}, 32'h1);
        reg_read(2'd0, d);
        idle();
        check("irq_below_threshold", {31'h0, irq}, 32'h0);
        reg_write(2'd3, 32'h18);
`endif

        for (int i = 0; i < 3; i++) push(16'(16'h77 + i));
        reg_write(2'd1, 32'h4321);
        reg_read(2'd2, d);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check("midop_reset_readdata", readdata, 32'h0);
        check("midop_reset_out_port", {16'h0, out_port}, 32'h0);
        model_reset();
        #2;
        reset = 1'b0;
        reg_read(2'd2, d);
        check("midop_reset_status", d, 32'h0008_0000);

        for (int i = 0; i < 400; i++) begin
            bit          cs, r, w;
            logic [31:0] wd;
            cs = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 1) == 1);
            w  = ($urandom_range(0, 2) == 0);
            wd = $urandom;
            if ($urandom_range(0, 7) != 0) wd[4:3] = 2'b00;
            cycle(cs, r, w, 2'($urandom_range(0, 3)), wd,
                  ($urandom_range(0, 1) == 1), 16'($urandom), ($urandom_range(0, 2) == 0));
        end
        reg_read(2'd2, d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
